// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte to a PS/2 device: clock inhibit, request-to-send, bits
// shifted on device clock falls (LSB first), odd parity, stop, ACK check,
// with start and transfer timeouts. Lines are open-drain; *_oe = 1 pulls low.
//
// Ports:
//   clk, rstn            system clock, synchronous active-low reset
//   PS2_clk, PS2_data    raw pad levels (asynchronous)
//   tx_data, tx_valid    command byte and request (taken when tx_ready)
//   tx_ready             high only when idle
//   busy                 high whenever not idle
//   PS2_clk_oe           pull PS/2 clock low
//   PS2_data_oe          pull PS/2 data low
//   done, err_code       end-of-transfer pulse; 0 ok, 1 no ACK,
//                        2 start timeout, 3 transfer timeout
module ps2_host_tx #(
  parameter int FILTER_LEN     = 8,
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe,
  output logic       done,
  output logic [1:0] err_code
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_T = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int TW    = $clog2(MAX_T) + 1;
  localparam int FW    = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    RTS,
    SHIFT,
    WAIT_IDLE,
    FINISH
  } state_t;

  // input conditioning
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= PS2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive samples disagreed with the filtered level
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt_clk;  // old level 1 means this change is a fall
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // control FSM and datapath
  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  assign err_code = err_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    // saturating timer: an all-ones value is above every threshold
    timer_d     = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    err_d       = err_q;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    PS2_clk_oe  = 1'b0;
    PS2_data_oe = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        timer_d  = '0;
        if (tx_valid) begin
          shreg_d   = tx_data;
          parity_d  = ~^tx_data;
          bit_cnt_d = '0;
          err_d     = 2'd0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        PS2_clk_oe = 1'b1;
        if (timer_q >= TW'(INHIBIT_CYCLES - 1)) begin
          state_d = START;
        end
      end

      // start bit goes low while the clock is still held
      START: begin
        PS2_clk_oe  = 1'b1;
        PS2_data_oe = 1'b1;
        timer_d     = '0;
        state_d     = RTS;
      end

      RTS: begin
        PS2_data_oe = 1'b1;
        if (timer_q > TW'(START_TIMEOUT)) begin
          err_d   = 2'd2;
          state_d = FINISH;
        end else if (fall) begin
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = SHIFT;
        end
      end

      // bit_cnt = number of falls seen; shreg_q[0] is the bit on the line
      SHIFT: begin
        if (bit_cnt_q <= 4'd8) begin
          PS2_data_oe = ~shreg_q[0];
        end else if (bit_cnt_q == 4'd9) begin
          PS2_data_oe = ~parity_q;
        end
        if (timer_q > TW'(XFER_TIMEOUT)) begin
          err_d   = 2'd3;
          state_d = FINISH;
        end else if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd7) begin
            shreg_d = {1'b0, shreg_q[7:1]};
          end
          if (bit_cnt_q == 4'd10) begin
            err_d   = dat_s2 ? 2'd1 : 2'd0;
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (timer_q > TW'(XFER_TIMEOUT)) begin
          err_d   = 2'd3;
          state_d = FINISH;
        end else if (filt_clk && dat_s2) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
//
// Ports of the DUT are all driven or observed here; the device model drives
// the open-drain lines together with the DUT pull-low enables.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int ST  = 5000;
  localparam int XT  = 20000;
  localparam int H   = 40;   // device clock half period in system clocks

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, PS2_clk_oe, PS2_data_oe, done;
  logic [1:0] err_code;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk_line  = ~PS2_clk_oe & ~dev_clk_low;
  wire  ps2_data_line = ~PS2_data_oe & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .FILTER_LEN     (2),
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .XFER_TIMEOUT   (XT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .PS2_clk     (ps2_clk_line),
    .PS2_data    (ps2_data_line),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .PS2_clk_oe  (PS2_clk_oe),
    .PS2_data_oe (PS2_data_oe),
    .done        (done),
    .err_code    (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // passive monitor
  int         done_cnt = 0;
  int         inh_cnt = 0;
  int         start_cnt = 0;
  logic [1:0] last_err = 2'd0;
  logic [1:0] done_oe = 2'd0;
  logic       prev_done = 1'b0;
  logic       busy_after = 1'b1;

  always @(negedge clk) begin
    if (PS2_clk_oe && !PS2_data_oe) inh_cnt++;
    if (PS2_clk_oe && PS2_data_oe) start_cnt++;
    if (prev_done) busy_after = busy;
    if (done) begin
      done_cnt++;
      last_err = err_code;
      done_oe  = {PS2_clk_oe, PS2_data_oe};
    end
    prev_done = done;
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 50000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits for request-to-send, samples the start bit, then produces n_edges
  // clock falls; data is sampled on each rising edge. ACK is pulled low
  // after rise 10 and released after rise 11.
  task automatic device(input int n_edges, input bit do_ack, output logic [10:0] rx);
    int t;
    rx = '0;
    t  = 0;
    while (!(ps2_clk_line && !ps2_data_line) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rts_seen", {31'd0, (t < 2000)}, 32'd1);
    repeat (H) @(negedge clk);
    rx[0] = ps2_data_line;
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) rx[k] = ps2_data_line;
      if (k == 10 && do_ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int base, input int limit, output int cyc);
    cyc = 0;
    while (done_cnt == base && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_cnt - base, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic good_xfer(input logic [7:0] b, input logic par, input bit poke_busy);
    logic [10:0] rx;
    int          i0, s0, d0, cyc;
    i0 = inh_cnt;
    s0 = start_cnt;
    d0 = done_cnt;
    send(b);
    if (poke_busy) begin
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      repeat (30) @(negedge clk);
      tx_valid = 1'b0;
    end
    device(11, 1'b1, rx);
    wait_done(d0, 3000, cyc);
    check("inhibit_len", inh_cnt - i0, INH);
    check("start_hold", start_cnt - s0, 32'd1);
    check("rx_start", {31'd0, rx[0]}, 32'd0);
    check("rx_data", {24'd0, rx[8:1]}, {24'd0, b});
    check("rx_parity", {31'd0, rx[9]}, {31'd0, par});
    check("rx_stop", {31'd0, rx[10]}, 32'd1);
    check("err_ok", {30'd0, last_err}, 32'd0);
    check("busy_after_done", {31'd0, busy_after}, 32'd0);
  endtask

  initial begin
    logic [10:0] rx;
    int          d0, i0, cyc;

    // reset state
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clk_oe", {31'd0, PS2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, PS2_data_oe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {30'd0, err_code}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED: six ones, odd parity bit 1; tx_valid while busy is ignored
    good_xfer(8'hED, 1'b1, 1'b1);
    i0 = inh_cnt;
    repeat (300) @(negedge clk);
    check("no_second_xfer", inh_cnt - i0, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 0xF4: five ones, parity 0
    good_xfer(8'hF4, 1'b0, 1'b0);

    // device never clocks: start timeout
    d0 = done_cnt;
    send(8'hF4);
    device(0, 1'b0, rx);
    wait_done(d0, ST + 1000, cyc);
    check("start_to_window", {31'd0, ((cyc + H) >= ST) && ((cyc + H) <= ST + 20)}, 32'd1);
    check("err_start_to", {30'd0, last_err}, 32'd2);
    check("start_to_release", {30'd0, done_oe}, 32'd0);

    // eleven edges, no ACK
    d0 = done_cnt;
    send(8'hFF);
    device(11, 1'b0, rx);
    wait_done(d0, 3000, cyc);
    check("noack_data", {24'd0, rx[8:1]}, 32'hFF);
    check("err_noack", {30'd0, last_err}, 32'd1);

    // device stops after five edges: transfer timeout
    d0 = done_cnt;
    send(8'h00);
    device(5, 1'b1, rx);
    wait_done(d0, XT + 2000, cyc);
    check("err_xfer_to", {30'd0, last_err}, 32'd3);
    check("xfer_to_release", {30'd0, done_oe}, 32'd0);

    // recovery: 0x5A has four ones, parity 1
    good_xfer(8'h5A, 1'b1, 1'b0);

    // reset mid-transfer after the fourth fall
    d0 = done_cnt;
    send(8'hED);
    device(4, 1'b1, rx);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("mrst_clk_oe", {31'd0, PS2_clk_oe}, 32'd0);
    check("mrst_data_oe", {31'd0, PS2_data_oe}, 32'd0);
    check("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    check("mrst_no_done", done_cnt - d0, 32'd0);
    check("mrst_err", {30'd0, err_code}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
